// File: rtl/text_render_scheduler.sv
// Console redraw sequencer: walks every text cell row-major, fetches {bg,fg,char},
// applies the cursor overlay, kicks the font renderer and streams glyph rows to the writer.
module text_render_scheduler #(
  parameter int CONSOLE_LINES        = 24,
  parameter int CONSOLE_COLUMNS      = 80,
  parameter int COLOR_NUMBERS_BITS   = 4,
  parameter int HEIGHT_PER_CHARACTER = 12,
  parameter int FONT_LATENCY         = 2,
  parameter int BLINK_LOG2           = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   cursorPosition,
  input  logic [3:0]                    cursorStates,
  output logic                          busy,
  output logic                          done,
  output logic                          text_rd,
  output logic [11:0]                   text_addr,
  input  logic [15:0]                   text_data,
  output logic                          font_req,
  output logic [7:0]                    char_out,
  output logic [COLOR_NUMBERS_BITS-1:0] fg_out,
  output logic [COLOR_NUMBERS_BITS-1:0] bg_out,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [6:0]                    wr_cell_x,
  output logic [4:0]                    wr_cell_y,
  output logic [3:0]                    wr_row
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, WAIT_FONT, WRITE, NEXT, DONE
  } stateType;

  localparam logic [6:0] LAST_COL       = 7'(CONSOLE_COLUMNS - 1);
  localparam logic [4:0] LAST_ROW       = 5'(CONSOLE_LINES - 1);
  localparam logic [3:0] LAST_GLYPH_ROW = 4'(HEIGHT_PER_CHARACTER - 1);
  localparam logic [7:0] LAST_WAIT      = 8'(FONT_LATENCY - 1);

  stateType              state;
  logic [6:0]            col;
  logic [4:0]            row;
  logic [7:0]            waitCnt;
  logic [BLINK_LOG2-1:0] frameCnt;
  logic [7:0]            curRow;
  logic [7:0]            curCol;
  logic [3:0]            curMode;

  logic [COLOR_NUMBERS_BITS-1:0] cellFg;
  logic [COLOR_NUMBERS_BITS-1:0] cellBg;
  logic cursorHere;
  logic cursorVisible;
  logic swapColours;

  assign cellFg = text_data[8 +: COLOR_NUMBERS_BITS];
  assign cellBg = text_data[12 +: COLOR_NUMBERS_BITS];

  // Zero-extended compare: a cursor outside the console can never match a cell.
  assign cursorHere    = (curRow == {3'b000, row}) && (curCol == {1'b0, col});
  assign cursorVisible = (curMode ==? 4'b??10) ||
                         ((curMode ==? 4'b??00) && !frameCnt[BLINK_LOG2-1]);
  assign swapColours   = cursorHere && cursorVisible;

  assign wr_cell_x = col;
  assign wr_cell_y = row;

  // NOTE: every register in this block uses <= so all state updates land together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      waitCnt   <= '0;
      frameCnt  <= '0;
      curRow    <= '0;
      curCol    <= '0;
      curMode   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      text_rd   <= 1'b0;
      text_addr <= '0;
      font_req  <= 1'b0;
      char_out  <= '0;
      fg_out    <= '0;
      bg_out    <= '0;
      wr_valid  <= 1'b0;
      wr_row    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            curRow    <= cursorPosition[15:8];
            curCol    <= cursorPosition[7:0];
            curMode   <= cursorStates;
            col       <= '0;
            row       <= '0;
            text_addr <= '0;
            busy      <= 1'b1;
            text_rd   <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          text_rd <= 1'b0;
          state   <= LATCH;
        end
        LATCH: begin
          char_out <= text_data[7:0];
          fg_out   <= swapColours ? cellBg : cellFg;
          bg_out   <= swapColours ? cellFg : cellBg;
          font_req <= 1'b1;
          waitCnt  <= '0;
          state    <= WAIT_FONT;
        end
        WAIT_FONT: begin
          font_req <= 1'b0;
          if (waitCnt == LAST_WAIT) begin
            wr_valid <= 1'b1;
            wr_row   <= '0;
            state    <= WRITE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        WRITE: begin
          // wr_valid is held for the whole state, so wr_ready alone marks the handshake.
          if (wr_ready) begin
            if (wr_row == LAST_GLYPH_ROW) begin
              wr_valid <= 1'b0;
              wr_row   <= '0;
              state    <= NEXT;
            end else begin
              wr_row <= wr_row + 4'd1;
            end
          end
        end
        NEXT: begin
          if (col == LAST_COL && row == LAST_ROW) begin
            col       <= '0;
            row       <= '0;
            text_addr <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 7'd1;
            end
            text_addr <= text_addr + 12'd1;
            text_rd   <= 1'b1;
            state     <= FETCH;
          end
        end
        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          frameCnt <= frameCnt + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_render_scheduler.sv
// Directed bench: a full-size instance for the whole-frame and cursor-address cases,
// plus a small console instance for stalls, blinking and cursor latching.
module tb_text_render_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-size console instance
  logic        rstA, startA, busyA, doneA, textRdA, fontReqA, wrValidA, wrReadyA;
  logic [15:0] curPosA, textDataA;
  logic [3:0]  curStA, fgA, bgA, wrRowA;
  logic [11:0] textAddrA;
  logic [7:0]  charA;
  logic [6:0]  wrXA;
  logic [4:0]  wrYA;

  text_render_scheduler dutA (
    .clk(clk), .rst(rstA), .start(startA), .cursorPosition(curPosA), .cursorStates(curStA),
    .busy(busyA), .done(doneA), .text_rd(textRdA), .text_addr(textAddrA), .text_data(textDataA),
    .font_req(fontReqA), .char_out(charA), .fg_out(fgA), .bg_out(bgA),
    .wr_valid(wrValidA), .wr_ready(wrReadyA), .wr_cell_x(wrXA), .wr_cell_y(wrYA), .wr_row(wrRowA)
  );

  // Small console: 2 lines x 3 columns, 4 glyph rows, 3-cycle font latency
  logic        rstB, startB, busyB, doneB, textRdB, fontReqB, wrValidB, wrReadyB;
  logic [15:0] curPosB, textDataB;
  logic [3:0]  curStB, fgB, bgB, wrRowB;
  logic [11:0] textAddrB;
  logic [7:0]  charB;
  logic [6:0]  wrXB;
  logic [4:0]  wrYB;

  text_render_scheduler #(
    .CONSOLE_LINES(2), .CONSOLE_COLUMNS(3), .HEIGHT_PER_CHARACTER(4), .FONT_LATENCY(3)
  ) dutB (
    .clk(clk), .rst(rstB), .start(startB), .cursorPosition(curPosB), .cursorStates(curStB),
    .busy(busyB), .done(doneB), .text_rd(textRdB), .text_addr(textAddrB), .text_data(textDataB),
    .font_req(fontReqB), .char_out(charB), .fg_out(fgB), .bg_out(bgB),
    .wr_valid(wrValidB), .wr_ready(wrReadyB), .wr_cell_x(wrXB), .wr_cell_y(wrYB), .wr_row(wrRowB)
  );

  // Text RAM models with one cycle of read latency
  always @(posedge clk)
    textDataA <= (textAddrA == 12'd245) ? 16'h1241 : {4'hA, 4'h5, textAddrA[7:0]};
  always @(posedge clk)
    textDataB <= {4'h9, 4'h3, textAddrB[7:0]};

  // One frame on the small console; optionally stalls randomly or pokes start/cursor mid-frame.
  task automatic runFrameB(input bit randReady, input bit poke,
                           output int hs, output int seqErr, output int stallErr,
                           output int doneCnt, output int charErr,
                           output logic [15:0] swapMask, output int cycles);
    int ex, ey, er, fr;
    logic pv;
    logic [15:0] px;
    hs = 0; seqErr = 0; stallErr = 0; doneCnt = 0; charErr = 0; swapMask = '0; cycles = 0;
    ex = 0; ey = 0; er = 0; fr = 0; pv = 1'b0; px = '0;
    @(negedge clk); startB = 1'b1;
    @(negedge clk); startB = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      cycles = c;
      if (poke && c == 3) begin startB = 1'b1; curPosB = 16'h0100; curStB = 4'h1; end
      if (poke && c == 4) startB = 1'b0;
      if (pv && (!wrValidB || {wrYB, wrXB, wrRowB} != px)) stallErr++;
      if (fontReqB) begin
        if (charB != 8'(fr)) charErr++;
        if (fgB == 4'h9 && bgB == 4'h3 && fr < 16) swapMask[fr] = 1'b1;
        else if (!(fgB == 4'h3 && bgB == 4'h9)) charErr++;
        fr++;
      end
      wrReadyB = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = 1'b0;
      if (wrValidB) begin
        if (wrReadyB) begin
          hs++;
          if (wrXB != 7'(ex) || wrYB != 5'(ey) || wrRowB != 4'(er)) seqErr++;
          er++;
          if (er == 4) begin er = 0; ex++; if (ex == 3) begin ex = 0; ey++; end end
        end else begin
          pv = 1'b1;
          px = {wrYB, wrXB, wrRowB};
        end
      end
      if (doneB) begin doneCnt++; break; end
    end
    wrReadyB = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (doneB) doneCnt++;
    end
  endtask

  initial begin
    int hs, seqErr, stallErr, doneCnt, charErr, cycles, fr, ex, ey, er, t4Err;
    logic [15:0] mask;
    bit finished;

    rstA = 1'b0; startA = 1'b0; curPosA = '0; curStA = 4'h1; wrReadyA = 1'b1;
    rstB = 1'b0; startB = 1'b0; curPosB = '0; curStB = 4'h1; wrReadyB = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl_a", 32'({busyA, doneA, textRdA, textAddrA, fontReqA, wrValidA, wrRowA}), 32'h0);
    check("reset_data_a", 32'({charA, fgA, bgA, wrXA, wrYA}), 32'h0);
    rstA = 1'b1; rstB = 1'b1;
    @(negedge clk);
    check("idle_not_busy", 32'(busyA), 32'h0);

    // T1: full default frame, writer always ready
    curPosA = 16'hFFFF; curStA = 4'h2;
    startA = 1'b1; @(negedge clk); startA = 1'b0;
    check("t1_busy_after_start", 32'(busyA), 32'h1);
    check("t1_first_fetch", 32'({textRdA, textAddrA}), 32'h1000);
    hs = 0; seqErr = 0; ex = 0; ey = 0; er = 0; finished = 0; cycles = 0;
    for (int c = 1; c <= 40000; c++) begin
      if (c > 1) @(negedge clk);
      if (wrValidA) begin
        if (wrXA != 7'(ex) || wrYA != 5'(ey) || wrRowA != 4'(er)) seqErr++;
        hs++; er++;
        if (er == 12) begin er = 0; ex++; if (ex == 80) begin ex = 0; ey++; end end
      end
      if (doneA) begin cycles = c; finished = 1; break; end
    end
    check("t1_finished", 32'(finished), 32'h1);
    check("t1_handshakes", 32'(hs), 32'd23040);
    check("t1_order", 32'(seqErr), 32'h0);
    check("t1_frame_cycles", 32'(cycles), 32'd32641);
    @(negedge clk);
    check("t1_done_one_cycle", 32'({doneA, busyA}), 32'h0);
    check("t1_counters_wrapped", 32'({textAddrA, wrXA, wrYA}), 32'h0);

    // T2: persistent cursor at row 3 col 5 (address 245); cursor changed after start
    curPosA = 16'h0305; curStA = 4'h2;
    startA = 1'b1; @(negedge clk); startA = 1'b0;
    curPosA = 16'h0000; curStA = 4'h1;
    fr = 0; finished = 0;
    for (int c = 1; c <= 6000; c++) begin
      if (c > 1) @(negedge clk);
      if (fontReqA) begin
        if (fr == 0)   check("t2_cell0_latched_cursor", 32'({charA, fgA, bgA}), 32'h005A);
        if (fr == 244) check("t2_cell244", 32'({charA, fgA, bgA}), 32'hF45A);
        if (fr == 245) check("t2_cell245_swap", 32'({charA, fgA, bgA}), 32'h4112);
        fr++;
      end
      if (fr == 246 && wrValidA && wrRowA == 4'd3) begin finished = 1; break; end
    end
    check("t6_reached_write", 32'(finished), 32'h1);
    check("t6_write_cell", 32'({wrXA, wrYA}), 32'({7'd5, 5'd3}));

    // T6: asynchronous reset mid-WRITE, then a fresh frame from cell 0
    #1 rstA = 1'b0;
    #1;
    check("t6_reset_ctrl", 32'({busyA, doneA, textRdA, textAddrA, fontReqA, wrValidA, wrRowA}), 32'h0);
    check("t6_reset_data", 32'({charA, fgA, bgA, wrXA, wrYA}), 32'h0);
    @(negedge clk); rstA = 1'b1;
    @(negedge clk);
    check("t6_idle_after_reset", 32'({busyA, doneA}), 32'h0);
    curPosA = 16'hFFFF; curStA = 4'h1;
    startA = 1'b1; @(negedge clk); startA = 1'b0;
    check("t6_restart_fetch", 32'({textRdA, textAddrA}), 32'h1000);
    repeat (2) @(negedge clk);
    check("t6_restart_font", 32'({fontReqA, charA, fgA, bgA}), 32'h1005A);
    repeat (2) @(negedge clk);
    check("t6_restart_write", 32'({wrValidA, wrXA, wrYA, wrRowA}), 32'h10000);
    rstA = 1'b0;

    // T3: random back-pressure on the small console
    curPosB = 16'h0000; curStB = 4'h1;
    runFrameB(1'b1, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("t3_handshakes", 32'(hs), 32'd24);
    check("t3_order", 32'(seqErr), 32'h0);
    check("t3_stall_stable", 32'(stallErr), 32'h0);
    check("t3_one_done", 32'(doneCnt), 32'h1);
    check("t3_chars", 32'(charErr), 32'h0);
    check("t3_no_cursor", 32'(mask), 32'h0);

    // T4: blinking cursor on the last cell over 33 frames from a fresh frame counter
    @(negedge clk); rstB = 1'b0;
    @(negedge clk); rstB = 1'b1;
    t4Err = 0;
    for (int f = 0; f <= 32; f++) begin
      curPosB = 16'h0102; curStB = 4'h0;
      runFrameB(1'b0, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
      check($sformatf("t4_blink_frame%0d", f), 32'(mask), (f < 16 || f == 32) ? 32'h20 : 32'h0);
      if (cycles != 61 || doneCnt != 1 || hs != 24 || seqErr != 0 || charErr != 0) t4Err++;
    end
    check("t4_frames_clean", 32'(t4Err), 32'h0);

    // T5: start and cursor poked mid-frame are ignored
    curPosB = 16'h0001; curStB = 4'h2;
    runFrameB(1'b0, 1'b1, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("t5_latched_cursor", 32'(mask), 32'h2);
    check("t5_one_done", 32'(doneCnt), 32'h1);
    check("t5_frame_cycles", 32'(cycles), 32'd61);
    check("t5_no_restart", 32'(busyB), 32'h0);

    // Cursor boundaries: out-of-range column/row, state 3, unused state bits set
    curPosB = 16'h00C8; curStB = 4'h2;
    runFrameB(1'b0, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("cursor_col_outside", 32'(mask), 32'h0);
    curPosB = 16'h0500; curStB = 4'h2;
    runFrameB(1'b0, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("cursor_row_outside", 32'(mask), 32'h0);
    curPosB = 16'h0000; curStB = 4'h3;
    runFrameB(1'b0, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("cursor_state3_invisible", 32'(mask), 32'h0);
    curPosB = 16'h0102; curStB = 4'hE;
    runFrameB(1'b0, 1'b0, hs, seqErr, stallErr, doneCnt, charErr, mask, cycles);
    check("cursor_upper_bits_ignored", 32'(mask), 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
